// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
// Also used by the testbench so both sides agree on MAXWAIT/LOCKMAX.
package dmem_arb_pkg;

  typedef enum logic {S_CPU, S_LOCK} arb_state_t;

  localparam int DEF_MAXWAIT = 4;
  localparam int DEF_LOCKMAX = 8;

  // Bits needed to hold 0..max inclusive, never less than one.
  function automatic int cnt_width(input int max);
    return (max < 2) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Used for the debug starvation counter and the lock-beat counter.
module sat_counter #(
  parameter int WIDTH = 3,
  parameter int MAX   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != WIDTH'(MAX))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the cpu and the debug/loader port.
// The cpu wins by default; a starvation counter and a bounded lock give debug its share.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DWIDTH  = 8,
  parameter int MAXWAIT = DEF_MAXWAIT,
  parameter int LOCKMAX = DEF_LOCKMAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [DWIDTH-1:0] cpu_adr,
  input  logic [DWIDTH-1:0] cpu_wd,
  output logic [DWIDTH-1:0] cpu_rd,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic              dbg_lock,
  input  logic [DWIDTH-1:0] dbg_adr,
  input  logic [DWIDTH-1:0] dbg_wd,
  output logic [DWIDTH-1:0] dbg_rd,
  output logic              dbg_ack,
  output logic              mem_we,
  output logic [DWIDTH-1:0] mem_adr,
  output logic [DWIDTH-1:0] mem_wd,
  input  logic [DWIDTH-1:0] mem_rd
);

  localparam int WW = cnt_width(MAXWAIT);
  localparam int LW = cnt_width(LOCKMAX - 1);

  arb_state_t      state, state_next;
  logic [WW-1:0]   wait_cnt;
  logic [LW-1:0]   lock_cnt;
  logic            grant_dbg;
  logic            ack_int;
  logic            in_lock;
  logic            lock_last;

  assign in_lock   = (state == S_LOCK);
  assign lock_last = (lock_cnt == LW'(LOCKMAX - 1));
  assign grant_dbg = in_lock | (dbg_req & (~cpu_req | (wait_cnt == WW'(MAXWAIT))));
  assign ack_int   = grant_dbg & dbg_req;

  assign cpu_rd = mem_rd;
  assign dbg_rd = mem_rd;

  // Handshakes and write enable are gated by reset so an in-flight write never commits.
  always_comb begin
    mem_adr   = cpu_adr;
    mem_wd    = cpu_wd;
    mem_we    = cpu_req & cpu_we;
    dbg_ack   = ack_int;
    cpu_stall = cpu_req & grant_dbg;
    if (grant_dbg) begin
      mem_adr = dbg_adr;
      mem_wd  = dbg_wd;
      mem_we  = dbg_req & dbg_we;
    end
    if (!reset) begin
      mem_we    = 1'b0;
      dbg_ack   = 1'b0;
      cpu_stall = 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_CPU:   if (ack_int && dbg_lock) state_next = S_LOCK;
      S_LOCK:  if (!dbg_lock || lock_last) state_next = S_CPU;
      default: state_next = S_CPU;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_CPU;
    end else begin
      state <= state_next;
    end
  end

  sat_counter #(.WIDTH(WW), .MAX(MAXWAIT)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (ack_int),
    .inc   (dbg_req & ~grant_dbg),
    .count (wait_cnt)
  );

  // Held at zero outside the lock so every burst starts counting from its first locked beat.
  sat_counter #(.WIDTH(LW), .MAX(LOCKMAX - 1)) u_lock_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (~in_lock),
    .inc   (in_lock),
    .count (lock_cnt)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios followed by random traffic,
// predicted by a cycle-level reference model of the arbitration rules.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int DW = 8;
  localparam int MW = DEF_MAXWAIT;
  localparam int LM = DEF_LOCKMAX;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_stall;
  logic [DW-1:0] cpu_adr, cpu_wd, cpu_rd;
  logic          dbg_req, dbg_we, dbg_lock, dbg_ack;
  logic [DW-1:0] dbg_adr, dbg_wd, dbg_rd;
  logic          mem_we;
  logic [DW-1:0] mem_adr, mem_wd, mem_rd;

  always #5 clk = ~clk;

  dmem_arbiter #(.DWIDTH(DW), .MAXWAIT(MW), .LOCKMAX(LM)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_adr   (cpu_adr),
    .cpu_wd    (cpu_wd),
    .cpu_rd    (cpu_rd),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_lock  (dbg_lock),
    .dbg_adr   (dbg_adr),
    .dbg_wd    (dbg_wd),
    .dbg_rd    (dbg_rd),
    .dbg_ack   (dbg_ack),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd)
  );

  // Behavioural single-port memory with combinational read.
  logic [DW-1:0] dmem [256];
  logic          clear_mem;
  assign mem_rd = dmem[mem_adr];

  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < 256; i++) dmem[i] <= '0;
    end else if (mem_we) begin
      dmem[mem_adr] <= mem_wd;
    end
  end

  typedef struct {
    logic          ack;
    logic          stall;
    logic          we;
    logic [DW-1:0] adr;
    logic [DW-1:0] wd;
    logic          chk_cpu;
    logic [DW-1:0] cpu_val;
    logic          chk_dbg;
    logic [DW-1:0] dbg_val;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model: ownership, how long debug has waited, and beats spent locked.
  bit            m_lock      = 0;
  int            m_waited    = 0;
  int            m_beats     = 0;
  bit            m_ack_last  = 0;
  logic [DW-1:0] ref_mem [256];

  task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic rst_n, input logic c_req, input logic c_we,
                                input logic [DW-1:0] c_adr, input logic [DW-1:0] c_wd,
                                input logic d_req, input logic d_we, input logic d_lock,
                                input logic [DW-1:0] d_adr, input logic [DW-1:0] d_wd);
    exp_t e;
    bit   wins;
    @(posedge clk);
    #1;
    reset    = rst_n;
    cpu_req  = c_req;
    cpu_we   = c_we;
    cpu_adr  = c_adr;
    cpu_wd   = c_wd;
    dbg_req  = d_req;
    dbg_we   = d_we;
    dbg_lock = d_lock;
    dbg_adr  = d_adr;
    dbg_wd   = d_wd;
    e = '{default: '0};
    if (!rst_n) begin
      m_lock     = 0;
      m_waited   = 0;
      m_beats    = 0;
      m_ack_last = 0;
    end else begin
      wins      = m_lock || (d_req && (!c_req || m_waited >= MW));
      e.ack     = wins && d_req;
      e.stall   = c_req && wins;
      e.we      = wins ? (d_req && d_we) : (c_req && c_we);
      e.adr     = wins ? d_adr : c_adr;
      e.wd      = wins ? d_wd : c_wd;
      e.chk_cpu = c_req && !wins && !c_we;
      e.cpu_val = ref_mem[c_adr];
      e.chk_dbg = e.ack && !d_we;
      e.dbg_val = ref_mem[d_adr];
      if (e.we) ref_mem[e.adr] = e.wd;
      if (e.ack) m_waited = 0;
      else if (d_req && m_waited < MW) m_waited++;
      if (m_lock) begin
        m_beats++;
        if (!d_lock || m_beats == LM) m_lock = 0;
      end else if (e.ack && d_lock) begin
        m_lock  = 1;
        m_beats = 0;
      end
      m_ack_last = e.ack;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("dbg_ack", {7'b0, dbg_ack}, {7'b0, e.ack});
        check_output("cpu_stall", {7'b0, cpu_stall}, {7'b0, e.stall});
        check_output("mem_we", {7'b0, mem_we}, {7'b0, e.we});
        if (e.we) begin
          check_output("mem_adr", mem_adr, e.adr);
          check_output("mem_wd", mem_wd, e.wd);
        end
        if (e.chk_cpu) check_output("cpu_rd", cpu_rd, e.cpu_val);
        if (e.chk_dbg) check_output("dbg_rd", dbg_rd, e.dbg_val);
      end
    end
  end

  initial begin
    logic          r_dreq, r_dwe, r_dlock, r_rst;
    logic [DW-1:0] r_dadr, r_dwd;
    int            n;
    reset = 1'b0; clear_mem = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_adr = '0; cpu_wd = '0;
    dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_adr = '0; dbg_wd = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    $display("[TB] reset holds off a cpu store");
    apply_stimulus(0, 1, 1, 8'h10, 8'hFF, 0, 0, 0, 8'h00, 8'h00);
    clear_mem = 1'b0;
    apply_stimulus(0, 1, 1, 8'h10, 8'hFF, 0, 0, 0, 8'h00, 8'h00);

    $display("[TB] cpu store then idle-cpu debug read");
    apply_stimulus(1, 1, 1, 8'h10, 8'h5A, 0, 0, 0, 8'h00, 8'h00);
    apply_stimulus(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h10, 8'h00);

    $display("[TB] debug write forced through a busy cpu");
    n = 0;
    do begin
      apply_stimulus(1, 1, 0, 8'h10, 8'h00, 1, 1, 0, 8'h20, 8'h33);
      n++;
    end while (!m_ack_last && n < 20);
    apply_stimulus(1, 1, 0, 8'h20, 8'h00, 0, 0, 0, 8'h00, 8'h00);

    $display("[TB] three-beat locked burst");
    n = 0;
    do begin
      apply_stimulus(1, 1, 0, 8'h11, 8'h00, 1, 1, 1, 8'h30, 8'hA0);
      n++;
    end while (!m_ack_last && n < 20);
    apply_stimulus(1, 1, 0, 8'h11, 8'h00, 1, 1, 1, 8'h31, 8'hA1);
    apply_stimulus(1, 1, 0, 8'h11, 8'h00, 1, 1, 0, 8'h32, 8'hA2);
    apply_stimulus(1, 1, 0, 8'h30, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    apply_stimulus(1, 1, 0, 8'h32, 8'h00, 0, 0, 0, 8'h00, 8'h00);

    $display("[TB] lock held past its limit");
    n = 0;
    do begin
      apply_stimulus(1, 1, 0, 8'h12, 8'h00, 1, 1, 1, 8'h40, 8'hB0);
      n++;
    end while (!m_ack_last && n < 20);
    n = 1;
    while (m_lock && n < 20) begin
      apply_stimulus(1, 1, 0, 8'h12, 8'h00, 1, 1, 1, 8'(8'h40 + n), 8'(8'hB0 + n));
      n++;
    end
    for (int i = 0; i < 6; i++)
      apply_stimulus(1, 1, 0, 8'h40, 8'h00, 1, 1, 0, 8'h60, 8'h66);

    $display("[TB] reset during a locked beat");
    n = 0;
    do begin
      apply_stimulus(1, 1, 0, 8'h13, 8'h00, 1, 1, 1, 8'h50, 8'hC0);
      n++;
    end while (!m_ack_last && n < 20);
    apply_stimulus(0, 1, 0, 8'h13, 8'h00, 1, 1, 1, 8'h51, 8'h77);
    apply_stimulus(1, 1, 0, 8'h51, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    apply_stimulus(1, 1, 0, 8'h50, 8'h00, 0, 0, 0, 8'h00, 8'h00);

    $display("[TB] random traffic");
    r_dreq = 0; r_dwe = 0; r_dlock = 0; r_dadr = '0; r_dwd = '0;
    for (int i = 0; i < 1500; i++) begin
      r_rst = ($urandom_range(0, 199) != 0);
      if (!r_dreq || m_ack_last) begin
        r_dreq = ($urandom_range(0, 2) == 0);
        r_dwe  = $urandom_range(0, 1) != 0;
        r_dadr = 8'($urandom_range(0, 31));
        r_dwd  = 8'($urandom);
      end
      r_dlock = ($urandom_range(0, 2) == 0);
      apply_stimulus(r_rst, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                     8'($urandom_range(0, 31)), 8'($urandom),
                     r_dreq, r_dwe, r_dlock, r_dadr, r_dwd);
    end
    apply_stimulus(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    apply_stimulus(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);

    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    #2;
    if (exp_q.size() > 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d records left, required 0", exp_q.size());
    end
    for (int i = 0; i < 256; i++)
      check_output($sformatf("dmem[%0h]", i), dmem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
